// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: walks a 4-input combinational function through all 16
// input codes, captures its truth table and compares it against a golden table.
// Optional macro LOGIC_SWEEP_SETTLE_EN adds a one-cycle SETTLE state between
// DRIVE and SAMPLE (3 cycles per index instead of 2).
module logic_sweep_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden,
    input  logic        e_in,
    output logic [3:0]  abcd_out,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] result,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_err_idx,
    output logic        err_flag
);

`ifdef LOGIC_SWEEP_SETTLE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SAMPLE, S_DONE
    } state_t;
`endif

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] golden_q;

    // Sweep sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 4'd0;
            golden_q      <= 16'd0;
            abcd_out      <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            result        <= 16'd0;
            mismatch_cnt  <= 5'd0;
            first_err_idx <= 4'd0;
            err_flag      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only on the
            // transition that owns them; non-blocking keeps the read of
            // mismatch_cnt below seeing the pre-edge value.
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_DRIVE;
                        idx           <= 4'd0;
                        golden_q      <= golden;
                        abcd_out      <= 4'd0;
                        busy          <= 1'b1;
                        result        <= 16'd0;
                        mismatch_cnt  <= 5'd0;
                        first_err_idx <= 4'd0;
                        err_flag      <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        abcd_out <= 4'd0;
                        busy     <= 1'b0;
                        aborted  <= 1'b1;
                    end else begin
`ifdef LOGIC_SWEEP_SETTLE_EN
                        state <= S_SETTLE;
`else
                        state <= S_SAMPLE;
`endif
                    end
                end
`ifdef LOGIC_SWEEP_SETTLE_EN
                S_SETTLE: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        abcd_out <= 4'd0;
                        busy     <= 1'b0;
                        aborted  <= 1'b1;
                    end else begin
                        state <= S_SAMPLE;
                    end
                end
`endif
                S_SAMPLE: begin
                    if (abort) begin
                        // Capture for this index is dropped on abort.
                        state    <= S_IDLE;
                        abcd_out <= 4'd0;
                        busy     <= 1'b0;
                        aborted  <= 1'b1;
                    end else begin
                        result[idx] <= e_in;
                        if (e_in != golden_q[idx]) begin
                            mismatch_cnt <= mismatch_cnt + 5'd1;
                            err_flag     <= 1'b1;
                            if (mismatch_cnt == 5'd0) begin
                                first_err_idx <= idx;
                            end
                        end
                        if (idx == 4'd15) begin
                            state    <= S_DONE;
                            abcd_out <= 4'd0;
                            done     <= 1'b1;
                        end else begin
                            state    <= S_DRIVE;
                            idx      <= idx + 4'd1;
                            abcd_out <= idx + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    abcd_out <= 4'd0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Self-checking bench for logic_sweep_ctrl: the function under test is a
// 16-entry truth table indexed by abcd_out; expectations come from a
// table-level model of the sweep.
module tb_logic_sweep_ctrl;

`ifdef LOGIC_SWEEP_SETTLE_EN
    localparam int CPI = 3;
`else
    localparam int CPI = 2;
`endif
    localparam int DONE_CYCLE = CPI * 16 + 1;

    logic        clk = 1'b0;
    logic        rst, start, abort, e_in;
    logic [15:0] golden;
    logic [3:0]  abcd_out;
    logic        busy, done, aborted, err_flag;
    logic [15:0] result;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err_idx;

    logic [15:0] tt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign e_in = tt[abcd_out];

    logic_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
        .e_in(e_in), .abcd_out(abcd_out), .busy(busy), .done(done),
        .aborted(aborted), .result(result), .mismatch_cnt(mismatch_cnt),
        .first_err_idx(first_err_idx), .err_flag(err_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: mismatches among the first n indices.
    function automatic int model_cnt(input logic [15:0] t, input logic [15:0] g, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (t[i] != g[i]) c++;
        return c;
    endfunction

    function automatic int model_first(input logic [15:0] t, input logic [15:0] g, input int n);
        for (int i = 0; i < n; i++) if (t[i] != g[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] model_mask(input logic [15:0] t, input int n);
        logic [15:0] m = 16'd0;
        for (int i = 0; i < n; i++) m[i] = t[i];
        return m;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_abcd"}, 32'(abcd_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_aborted"}, 32'(aborted), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_mcnt"}, 32'(mismatch_cnt), 0);
        chk({tag, "_first"}, 32'(first_err_idx), 0);
        chk({tag, "_err"}, 32'(err_flag), 0);
    endtask

    // Full sweep; returns while the DUT is in its DONE cycle.
    task automatic run_sweep(input string tag, input logic [15:0] t, input logic [15:0] g);
        int cyc;
        int abcd_bad = 0;
        int n;
        tt     = t;
        golden = g;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        golden = 16'($urandom);   // must not disturb the sweep in progress
        cyc = 1;
        chk({tag, "_busy"}, 32'(busy), 1);
        while (!done && cyc < 200) begin
            if (abcd_out !== 4'((cyc - 1) / CPI)) abcd_bad++;
            tick();
            cyc++;
        end
        chk({tag, "_abcd_seq"}, abcd_bad, 0);
        chk({tag, "_latency"}, cyc, DONE_CYCLE);
        chk({tag, "_done_busy"}, 32'(busy), 1);
        chk({tag, "_done_abcd"}, 32'(abcd_out), 0);
        n = model_cnt(t, g, 16);
        chk({tag, "_result"}, 32'(result), 32'(t));
        chk({tag, "_mcnt"}, 32'(mismatch_cnt), n);
        chk({tag, "_first"}, 32'(first_err_idx), model_first(t, g, 16));
        chk({tag, "_err"}, 32'(err_flag), (n != 0) ? 1 : 0);
    endtask

    logic [15:0] f_and;
    logic [15:0] rt, rg, held;
    int cyc;
    int bad;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; golden = 16'd0; tt = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_zero("reset");

        // a&b&(c xnor d) with a = index bit 3 ... d = index bit 0
        for (int i = 0; i < 16; i++)
            f_and[i] = i[3] & i[2] & ~(i[1] ^ i[0]);

        run_sweep("and_pass", f_and, 16'h9000);
        tick();
        chk("idle_after_done_busy", 32'(busy), 0);
        chk("idle_after_done_pulse", 32'(done), 0);
        run_sweep("and_one_err", f_and, 16'h1000);
        tick();
        run_sweep("all_ones", 16'hFFFF, 16'h0000);
        tick();

        for (int k = 0; k < 4; k++) begin
            rt = 16'($urandom);
            rg = (k == 0) ? rt : 16'($urandom);
            run_sweep($sformatf("rand%0d", k), rt, rg);
            tick();
        end

        // Results hold in IDLE; abort in IDLE is ignored.
        held = result;
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        chk("idle_abort_pulse", 32'(aborted), 0);
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_hold_result", 32'(result), 32'(held));

        // start and abort together in IDLE: start wins. Then abort at SAMPLE of idx 5.
        rt = 16'($urandom) | 16'h0020;
        rg = 16'($urandom);
        tt = rt; golden = rg;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_wins_busy", 32'(busy), 1);
        chk("start_wins_aborted", 32'(aborted), 0);
        cyc = 1;
        while (cyc < CPI * 5 + CPI) begin
            tick();
            cyc++;
        end
        chk("abort_pt_abcd", 32'(abcd_out), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 1);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_abcd", 32'(abcd_out), 0);
        chk("abort_result", 32'(result), 32'(model_mask(rt, 5)));
        chk("abort_mcnt", 32'(mismatch_cnt), model_cnt(rt, rg, 5));
        chk("abort_first", 32'(first_err_idx), model_first(rt, rg, 5));
        chk("abort_err", 32'(err_flag), (model_cnt(rt, rg, 5) != 0) ? 1 : 0);
        tick();
        chk("abort_pulse_one_cycle", 32'(aborted), 0);
        chk("abort_hold_result", 32'(result), 32'(model_mask(rt, 5)));

        // start during DONE is ignored.
        run_sweep("done_start", 16'h5A5A, 16'h5A5B);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", 32'(busy), 0);
        bad = 0;
        for (int i = 0; i < 3 * DONE_CYCLE; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("done_start_no_sweep", bad, 0);
        chk("done_start_hold_mcnt", 32'(mismatch_cnt), 1);

        // Reset at idx 8 mid-sweep.
        tt = 16'hFFFF; golden = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < CPI * 8 + 1) begin
            tick();
            cyc++;
        end
        chk("rst_pt_abcd", 32'(abcd_out), 8);
        chk("rst_pt_mcnt", 32'(mismatch_cnt), 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");
        bad = 0;
        for (int i = 0; i < 3 * DONE_CYCLE; i++) begin
            tick();
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_sweep_ctrl.md
LOGIC_SWEEP_CTRL -- requirements
Module: logic_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  sweep request, sampled only in IDLE.
REQ-005 Port abort  input  1  cancel the sweep in progress, sampled in DRIVE/SETTLE/SAMPLE.
REQ-006 Port golden  input  16  expected truth table; bit i is the expected output for input index i.
REQ-007 Port e_in  input  1  output of the external 4-input combinational function under test.
REQ-008 Port abcd_out  output  4  stimulus to the function: {a,b,c,d} = {abcd_out[3],abcd_out[2],abcd_out[1],abcd_out[0]}.
REQ-009 Port busy  output  1  high in every state except IDLE.
REQ-010 Port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 Port aborted  output  1  one-cycle pulse when a sweep is cancelled.
REQ-012 Port result  output  16  captured truth table; bit i is e_in sampled for index i.
REQ-013 Port mismatch_cnt  output  5  number of indices where result differs from the latched golden, range 0..16.
REQ-014 Port first_err_idx  output  4  lowest mismatching index; 0 when there is no mismatch.
REQ-015 Port err_flag  output  1  high when mismatch_cnt is nonzero.

Function
REQ-016 States SHALL be IDLE, DRIVE, SETTLE (only when configured), SAMPLE and DONE.
REQ-017 IDLE with start=1 SHALL move to DRIVE and, on that same edge, clear idx to 0, result to 0, mismatch_cnt to 0, first_err_idx to 0 and err_flag to 0, and latch golden into an internal register.
REQ-018 abcd_out SHALL equal idx in DRIVE, SETTLE and SAMPLE, and SHALL be 4'b0000 in IDLE and DONE.
REQ-019 DRIVE SHALL move to SETTLE when SETTLE is compiled in, and to SAMPLE otherwise.
REQ-020 SETTLE SHALL move to SAMPLE after exactly one cycle.
REQ-021 On the edge ending SAMPLE, the block SHALL write e_in into result[idx].
REQ-022 On the same edge, if e_in differs from golden[idx], the block SHALL increment mismatch_cnt and, if this is the first mismatch of the sweep, set first_err_idx to idx.
REQ-023 SAMPLE SHALL move to DRIVE with idx+1 when idx<15, and to DONE when idx=15 (no wrap of idx).
REQ-024 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-025 Latency without SETTLE: start accepted at edge 0, done high in cycle 33; 2 cycles per index.
REQ-026 Latency with SETTLE: done high in cycle 49; 3 cycles per index.
REQ-027 abort=1 in DRIVE, SETTLE or SAMPLE SHALL move to IDLE on the next edge with aborted=1 for that cycle and done=0.
REQ-028 On abort, the result bits and counters already captured SHALL be held, and the SAMPLE write coincident with abort SHALL be suppressed.
REQ-029 start while busy=1, including in DONE, SHALL be ignored.
REQ-030 abort in IDLE or DONE SHALL be ignored.
REQ-031 When start and abort are both high in IDLE, start SHALL win.
REQ-032 result, mismatch_cnt, first_err_idx and err_flag SHALL hold their values in IDLE until the next accepted start.
REQ-033 Changes on golden after start is accepted SHALL have no effect on the sweep in progress.

Reset
REQ-034 rst=1 SHALL, on the next edge and from any state, force IDLE, idx=0, abcd_out=0, busy=0, done=0, aborted=0, result=0, mismatch_cnt=0, first_err_idx=0, err_flag=0 and the latched golden to 0.
REQ-035 Reset asserted mid-sweep SHALL produce neither a done pulse nor an aborted pulse.

Configuration
REQ-036 Macro LOGIC_SWEEP_SETTLE_EN defined SHALL include the SETTLE state: 3 cycles per index, done in cycle 49.
REQ-037 Macro LOGIC_SWEEP_SETTLE_EN undefined SHALL remove SETTLE entirely: 2 cycles per index, done in cycle 33.
REQ-038 Ports and all other behaviour SHALL be identical in both builds.

Verification
REQ-039 e_in = a&b&(c xnor d), golden=16'h9000, start pulse -> result=16'h9000, mismatch_cnt=0, err_flag=0, done high in cycle 33 (49 with the macro defined).
REQ-040 Same function, golden=16'h1000 -> mismatch_cnt=1, first_err_idx=15, err_flag=1.
REQ-041 e_in tied to 1, golden=16'h0000 -> result=16'hFFFF, mismatch_cnt=16, first_err_idx=0, err_flag=1.
REQ-042 abort=1 in the SAMPLE cycle of idx=5 -> aborted pulse, no done, bits 0..4 of result captured, bit 5 not written, busy=0 on the next cycle.
REQ-043 start pulsed during DONE, and rst asserted at idx=8 -> start ignored with no second sweep; after reset every output is 0 and there is no done pulse.
